// File: rtl/elevator_call_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_call_scheduler
//
// Keeps the outstanding floor calls in a bitmap and picks the car's next
// target floor with SCAN: the car keeps its direction while calls remain
// ahead of it, and reverses only when calls exist on the other side. On
// arrival it opens the door for DOOR_CYCLES cycles and reports the served
// floor.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active high
//   call_req      one-cycle call pulses, bit i = floor i (several at once ok)
//   cur_floor     floor currently reported by the car
//   target_floor  floor the car is sent to
//   moving        high while the car is travelling to target_floor
//   dir_up        current SCAN direction, 1 = up
//   door_open     high during the door dwell
//   pending       registered outstanding-call bitmap
//   served_valid  one-cycle pulse when a floor is served
//   served_floor  floor served; holds its last value between pulses
// ---------------------------------------------------------------------------
module elevator_call_scheduler #(
   parameter int NUM_FLOORS  = 8,
   parameter int FLOOR_W     = 3,
   parameter int DOOR_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_W-1:0]    cur_floor,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  served_valid,
   output logic [FLOOR_W-1:0]    served_floor
);

   localparam int               CNT_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MOVE = 2'd1;
   localparam logic [1:0] S_DOOR = 2'd2;

   logic [1:0]            r_state;
   logic [NUM_FLOORS-1:0] r_pending;
   logic [FLOOR_W-1:0]    r_target;
   logic                  r_moving;
   logic                  r_dir_up;
   logic                  r_door_open;
   logic                  r_served_valid;
   logic [FLOOR_W-1:0]    r_served_floor;
   logic [CNT_W-1:0]      r_cnt;

   logic [1:0]            w_state_next;
   logic [NUM_FLOORS-1:0] w_pending_next;
   logic [FLOOR_W-1:0]    w_target_next;
   logic                  w_moving_next;
   logic                  w_dir_up_next;
   logic                  w_door_open_next;
   logic                  w_served_valid_next;
   logic [FLOOR_W-1:0]    w_served_floor_next;
   logic [CNT_W-1:0]      w_cnt_next;

   logic [NUM_FLOORS-1:0] w_req;
   logic [NUM_FLOORS-1:0] w_cur_bit;
   logic [NUM_FLOORS-1:0] w_clear;
   logic                  w_call_here;
   logic                  w_recall;
   logic                  w_serve;
   logic                  w_has_above;
   logic                  w_has_below;
   logic [FLOOR_W-1:0]    w_above;
   logic [FLOOR_W-1:0]    w_below;

   // Selection sees this cycle's calls as well as the registered ones.
   assign w_req       = r_pending | call_req;
   assign w_cur_bit   = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cur_floor;
   assign w_call_here = |(w_req & w_cur_bit);
   assign w_recall    = |(call_req & w_cur_bit);

   // Nearest call strictly above / below the car. The scan order makes the
   // last hit the closest one.
   always_comb begin
      w_has_above = 1'b0;
      w_above     = '0;
      w_has_below = 1'b0;
      w_below     = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (w_req[i] && (i > int'(cur_floor))) begin
            w_has_above = 1'b1;
            w_above     = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (w_req[i] && (i < int'(cur_floor))) begin
            w_has_below = 1'b1;
            w_below     = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_target_next       = r_target;
      w_moving_next       = r_moving;
      w_dir_up_next       = r_dir_up;
      w_door_open_next    = r_door_open;
      w_served_valid_next = 1'b0;
      w_served_floor_next = r_served_floor;
      w_cnt_next          = r_cnt;
      w_clear             = '0;
      w_serve             = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_req == '0) begin
               w_target_next = cur_floor;
            end else if (w_call_here) begin
               w_serve = 1'b1;
            end else begin
               w_state_next  = S_MOVE;
               w_moving_next = 1'b1;
               if (r_dir_up) begin
                  if (w_has_above) begin
                     w_target_next = w_above;
                  end else begin
                     w_target_next = w_below;
                     w_dir_up_next = 1'b0;
                  end
               end else begin
                  if (w_has_below) begin
                     w_target_next = w_below;
                  end else begin
                     w_target_next = w_above;
                     w_dir_up_next = 1'b1;
                  end
               end
            end
         end

         S_MOVE: begin
            if (cur_floor == r_target) begin
               w_serve = 1'b1;
            end else if (r_dir_up) begin
               // Only pull the target closer; never retarget backwards.
               if (w_has_above && (w_above < r_target)) begin
                  w_target_next = w_above;
               end
            end else begin
               if (w_has_below && (w_below > r_target)) begin
                  w_target_next = w_below;
               end
            end
         end

         S_DOOR: begin
            if (w_recall) begin
               // A call for the open floor is absorbed and holds the door.
               w_clear    = w_cur_bit;
               w_cnt_next = CNT_LOAD;
            end else if (r_cnt == '0) begin
               w_state_next     = S_IDLE;
               w_door_open_next = 1'b0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (w_serve) begin
         w_state_next        = S_DOOR;
         w_door_open_next    = 1'b1;
         w_moving_next       = 1'b0;
         w_served_valid_next = 1'b1;
         w_served_floor_next = cur_floor;
         w_clear             = w_cur_bit;
         w_cnt_next          = CNT_LOAD;
      end
   end

   // Clear beats a same-edge set of the same floor.
   assign w_pending_next = w_req & ~w_clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_pending      <= '0;
         r_target       <= '0;
         r_moving       <= 1'b0;
         r_dir_up       <= 1'b1;
         r_door_open    <= 1'b0;
         r_served_valid <= 1'b0;
         r_served_floor <= '0;
         r_cnt          <= '0;
      end else begin
         r_state        <= w_state_next;
         r_pending      <= w_pending_next;
         r_target       <= w_target_next;
         r_moving       <= w_moving_next;
         r_dir_up       <= w_dir_up_next;
         r_door_open    <= w_door_open_next;
         r_served_valid <= w_served_valid_next;
         r_served_floor <= w_served_floor_next;
         r_cnt          <= w_cnt_next;
      end
   end

   assign target_floor = r_target;
   assign moving       = r_moving;
   assign dir_up       = r_dir_up;
   assign door_open    = r_door_open;
   assign pending      = r_pending;
   assign served_valid = r_served_valid;
   assign served_floor = r_served_floor;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_scheduler
//
// Directed scenarios followed by a randomized run. A behavioural model of
// the scheduler (pending set, distance search, remaining door cycles) gives
// the expected outputs every cycle; a simple car model walks cur_floor
// toward the model's target.
// ---------------------------------------------------------------------------
module tb_elevator_call_scheduler;

   localparam int N  = 8;
   localparam int FW = 3;
   localparam int DC = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  call_req;
   logic [FW-1:0] cur_floor;
   logic [FW-1:0] target_floor;
   logic          moving;
   logic          dir_up;
   logic          door_open;
   logic [N-1:0]  pending;
   logic          served_valid;
   logic [FW-1:0] served_floor;

   elevator_call_scheduler #(
      .NUM_FLOORS (N),
      .FLOOR_W    (FW),
      .DOOR_CYCLES(DC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .call_req    (call_req),
      .cur_floor   (cur_floor),
      .target_floor(target_floor),
      .moving      (moving),
      .dir_up      (dir_up),
      .door_open   (door_open),
      .pending     (pending),
      .served_valid(served_valid),
      .served_floor(served_floor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit [N-1:0] m_pend;
   int         m_target;
   bit         m_moving;
   bit         m_dir;
   int         m_door_left;   // door_open cycles still to come
   bit         m_sv;
   int         m_sf;

   // Car model and observation
   int car_pos;
   int car_cnt;
   int car_period;
   int served_q[$];
   int door_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Closest requested floor strictly in the given direction, or -1.
   function automatic int nearest(input bit [N-1:0] req, input int cur, input bit up);
      for (int d = 1; d < N; d++) begin
         int f;
         f = up ? cur + d : cur - d;
         if (f >= 0 && f < N && req[f]) return f;
      end
      return -1;
   endfunction

   function automatic int served_at(input int idx);
      if (idx < served_q.size()) return served_q[idx];
      return -1;
   endfunction

   task automatic model_serve(input int cur, inout bit [N-1:0] req);
      m_door_left = DC;
      m_moving    = 1'b0;
      m_sv        = 1'b1;
      m_sf        = cur;
      req[cur]    = 1'b0;
   endtask

   task automatic model_step(input bit r, input bit [N-1:0] c, input int cur);
      bit [N-1:0] req;
      int a;
      if (r) begin
         m_pend = '0; m_target = 0; m_moving = 0; m_dir = 1;
         m_door_left = 0; m_sv = 0; m_sf = 0;
         return;
      end
      req  = m_pend | c;
      m_sv = 1'b0;
      if (m_door_left > 0) begin
         if (c[cur]) begin
            m_door_left = DC;
            req[cur]    = 1'b0;
         end else begin
            m_door_left--;
         end
      end else if (m_moving) begin
         if (cur == m_target) begin
            model_serve(cur, req);
         end else begin
            a = nearest(req, cur, m_dir);
            if (a >= 0 && iabs(a - cur) < iabs(m_target - cur)) m_target = a;
         end
      end else begin
         if (req == '0) begin
            m_target = cur;
         end else if (req[cur]) begin
            model_serve(cur, req);
         end else begin
            a = nearest(req, cur, m_dir);
            if (a < 0) begin
               m_dir = !m_dir;
               a = nearest(req, cur, m_dir);
            end
            m_target = a;
            m_moving = 1'b1;
         end
      end
      m_pend = req;
   endtask

   // One clock: model update at the edge, compare 1 time unit later, then
   // advance the car.
   task automatic step();
      @(posedge clk);
      model_step(rst, call_req, car_pos);
      #1;
      chk("target_floor", 32'(target_floor), 32'(m_target));
      chk("moving",       32'(moving),       32'(m_moving));
      chk("dir_up",       32'(dir_up),       32'(m_dir));
      chk("door_open",    32'(door_open),    32'(m_door_left > 0));
      chk("pending",      32'(pending),      32'(m_pend));
      chk("served_valid", 32'(served_valid), 32'(m_sv));
      chk("served_floor", 32'(served_floor), 32'(m_sf));
      if (served_valid === 1'b1) served_q.push_back(int'(served_floor));
      if (door_open === 1'b1) door_cnt++;
      if (!rst && m_moving && car_pos != m_target) begin
         car_cnt++;
         if (car_cnt >= car_period) begin
            car_cnt = 0;
            car_pos = (m_target > car_pos) ? car_pos + 1 : car_pos - 1;
         end
      end else begin
         car_cnt = 0;
      end
      cur_floor = FW'(car_pos);
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n;
      n = 0;
      while ((m_moving || m_door_left > 0 || m_pend != '0) && n < max_cycles) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(m_moving || m_door_left > 0 || m_pend != '0), 0);
   endtask

   task automatic wait_car(input int floor, input int max_cycles);
      int n;
      n = 0;
      while (car_pos != floor && n < max_cycles) begin
         step();
         n++;
      end
      chk("car_timeout", 32'(car_pos), 32'(floor));
   endtask

   task automatic place_car(input int floor);
      car_pos   = floor;
      cur_floor = FW'(floor);
      step();
   endtask

   initial begin
      int mask;
      rst        = 1'b1;
      call_req   = 8'hFF;
      car_pos    = 0;
      car_cnt    = 0;
      car_period = 1;
      cur_floor  = '0;
      door_cnt   = 0;

      // Reset with calls asserted: calls ignored, reset values everywhere.
      step();
      step();
      chk("rst_pending", 32'(pending), 0);
      chk("rst_target",  32'(target_floor), 0);
      chk("rst_moving",  32'(moving), 0);
      chk("rst_dir",     32'(dir_up), 1);
      chk("rst_door",    32'(door_open), 0);
      chk("rst_sv",      32'(served_valid), 0);
      rst      = 1'b0;
      call_req = '0;
      step();
      chk("post_rst_pending", 32'(pending), 0);

      // Single call to floor 5 from ground.
      served_q.delete();
      door_cnt = 0;
      call_req = 8'h20;
      step();
      call_req = '0;
      chk("single_moving",  32'(moving), 1);
      chk("single_target",  32'(target_floor), 5);
      chk("single_dir",     32'(dir_up), 1);
      chk("single_pending", 32'(pending), 32'h20);
      run_until_idle(100);
      chk("single_nserved", 32'(served_q.size()), 1);
      chk("single_floor",   32'(served_at(0)), 5);
      chk("single_door",    32'(door_cnt), DC);
      chk("single_pend0",   32'(pending), 0);

      // Retarget: heading 1 -> 6, call 4 appears at floor 2.
      place_car(1);
      call_req = 8'h40;
      step();
      call_req = '0;
      chk("retgt_target6", 32'(target_floor), 6);
      wait_car(2, 50);
      served_q.delete();
      call_req = 8'h10;
      step();
      call_req = '0;
      chk("retgt_target4", 32'(target_floor), 4);
      run_until_idle(200);
      chk("retgt_nserved", 32'(served_q.size()), 2);
      chk("retgt_first",   32'(served_at(0)), 4);
      chk("retgt_second",  32'(served_at(1)), 6);

      // SCAN reversal from floor 3 going up with calls at 1 and 6.
      place_car(3);
      served_q.delete();
      call_req = 8'h42;
      step();
      call_req = '0;
      chk("scan_target", 32'(target_floor), 6);
      chk("scan_dir_up", 32'(dir_up), 1);
      run_until_idle(300);
      chk("scan_nserved", 32'(served_q.size()), 2);
      chk("scan_first",   32'(served_at(0)), 6);
      chk("scan_second",  32'(served_at(1)), 1);
      chk("scan_dir_dn",  32'(dir_up), 0);

      // Door re-call at floor 2 extends the dwell by a full period.
      place_car(2);
      served_q.delete();
      door_cnt = 0;
      call_req = 8'h04;
      step();
      call_req = '0;
      chk("recall_sv",   32'(served_valid), 1);
      chk("recall_door", 32'(door_open), 1);
      step();
      call_req = 8'h04;
      step();
      call_req = '0;
      chk("recall_pend2", 32'(pending[2]), 0);
      run_until_idle(100);
      chk("recall_doorcnt", 32'(door_cnt), 2 + DC);
      chk("recall_nserved", 32'(served_q.size()), 1);

      // Call at floor 2 on the same edge the car arrives there.
      place_car(0);
      call_req = 8'h04;
      step();
      call_req = '0;
      chk("simul_target", 32'(target_floor), 2);
      served_q.delete();
      wait_car(2, 50);
      call_req = 8'h04;
      step();
      call_req = '0;
      chk("simul_sv",    32'(served_valid), 1);
      chk("simul_pend2", 32'(pending[2]), 0);
      run_until_idle(100);
      chk("simul_nserved", 32'(served_q.size()), 1);

      // Every floor called at once: all served exactly once.
      served_q.delete();
      call_req = 8'hFF;
      step();
      call_req = '0;
      run_until_idle(1000);
      mask = 0;
      foreach (served_q[k]) mask |= (1 << served_q[k]);
      chk("all_nserved", 32'(served_q.size()), N);
      chk("all_mask",    32'(mask), 32'hFF);
      chk("all_pending", 32'(pending), 0);

      // Reset in the middle of a move.
      call_req = 8'h80;
      step();
      call_req = 8'h02;
      step();
      call_req = '0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_moving",  32'(moving), 0);
      chk("midrst_pending", 32'(pending), 0);
      chk("midrst_target",  32'(target_floor), 0);
      chk("midrst_dir",     32'(dir_up), 1);

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 250 == 0) car_period = $urandom_range(1, 3);
         call_req = '0;
         if ($urandom_range(0, 3) == 0) call_req = N'(1) << $urandom_range(0, N - 1);
         if ($urandom_range(0, 39) == 0) call_req = N'($urandom);
         rst = ($urandom_range(0, 599) == 0);
         step();
      end
      rst      = 1'b0;
      call_req = '0;
      run_until_idle(2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
